// File: rtl/md_pkg.sv
// ============================================================================
// Module : md_pkg
// Brief  : Op encodings and FSM state encoding for the multicycle mul/div unit
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_iter_step.sv
// ============================================================================
// Module : md_iter_step
// Brief  : One radix-2 iteration: shift-add multiply or restoring divide step
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_accHi,
    input  logic [WIDTH-1:0] i_accLo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_nextHi,
    output logic [WIDTH-1:0] o_nextLo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_accHi} + {1'b0, i_operand};
        w_shifted = {i_accHi, i_accLo[WIDTH-1]};
        // Only used when shifted >= divisor, so the result fits in WIDTH bits
        w_diff    = w_shifted[WIDTH-1:0] - i_operand;
        o_nextHi  = i_accHi;
        o_nextLo  = i_accLo;
        if (i_isDiv) begin
            if (w_shifted >= {1'b0, i_operand}) begin
                o_nextHi = w_diff;
                o_nextLo = {i_accLo[WIDTH-2:0], 1'b1};
            end else begin
                o_nextHi = w_shifted[WIDTH-1:0];
                o_nextLo = {i_accLo[WIDTH-2:0], 1'b0};
            end
        end else if (i_accLo[0]) begin
            o_nextHi = w_sum[WIDTH:1];
            o_nextLo = {w_sum[0], i_accLo[WIDTH-1:1]};
        end else begin
            o_nextHi = {1'b0, i_accHi[WIDTH-1:1]};
            o_nextLo = {i_accHi[0], i_accLo[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_seq_unit.sv
// ============================================================================
// Module : md_seq_unit
// Brief  : Multicycle signed/unsigned multiply/divide unit with HI/LO regs.
//          Optional div_zero flag port when MD_DIVZERO_FLAG_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MD_DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    import md_pkg::*;

    md_state_e          r_state;
    md_state_e          w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_accHi;
    logic [WIDTH-1:0]   r_accLo;
    logic [WIDTH-1:0]   r_operand;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_isSigned;
    logic               w_isDivOp;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH-1:0]   w_nextHi;
    logic [WIDTH-1:0]   w_nextLo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_isSigned = (op == MD_MULT) || (op == MD_DIV);
    assign w_isDivOp  = (op == MD_DIV) || (op == MD_DIVU);
    assign w_aNeg     = w_isSigned && a[WIDTH-1];
    assign w_bNeg     = w_isSigned && b[WIDTH-1];
    assign w_absA     = w_aNeg ? -a : a;
    assign w_absB     = w_bNeg ? -b : b;
    assign w_prod     = {r_accHi, r_accLo};

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_isDiv   (r_isDiv),
        .i_accHi   (r_accHi),
        .i_accLo   (r_accLo),
        .i_operand (r_operand),
        .o_nextHi  (w_nextHi),
        .o_nextLo  (w_nextLo)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start && (op <= MD_DIVU)) w_nextState = CALC;
            CALC:    if (r_count == CNT_W'(WIDTH - 1)) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_operand <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && (op <= MD_DIVU)) begin
                        r_count   <= '0;
                        r_accHi   <= '0;
                        r_accLo   <= w_isDivOp ? w_absA : w_absB;
                        r_operand <= w_isDivOp ? w_absB : w_absA;
                        r_isDiv   <= w_isDivOp;
                        r_negRes  <= w_aNeg ^ w_bNeg;
                        r_negRem  <= w_aNeg;
                        r_divZero <= w_isDivOp && (b == '0);
                    end else if (start && (op == MD_MTHI)) begin
                        r_hi <= a;
                    end else if (start && (op == MD_MTLO)) begin
                        r_lo <= a;
                    end
                end
                CALC: begin
                    r_accHi <= w_nextHi;
                    r_accLo <= w_nextLo;
                    r_count <= r_count + CNT_W'(1);
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_isDiv) begin
                        // Remainder follows the dividend; a zero divisor forces all-ones quotient
                        r_hi <= r_negRem ? -r_accHi : r_accHi;
                        r_lo <= r_divZero ? '1 : (r_negRes ? -r_accLo : r_accLo);
                    end else begin
                        {r_hi, r_lo} <= r_negRes ? -w_prod : w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MD_DIVZERO_FLAG_EN
    logic r_dzFlag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dzFlag <= 1'b0;
        end else if ((r_state == FIX) && r_isDiv && r_divZero) begin
            r_dzFlag <= 1'b1;
        end else if (start && (r_state == IDLE) && (op <= MD_MTLO)) begin
            r_dzFlag <= 1'b0;
        end
    end

    assign div_zero = r_dzFlag;
`endif

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_seq_unit.sv
// ============================================================================
// Module : tb_md_seq_unit
// Brief  : Self-checking bench for md_seq_unit against a behavioural model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_seq_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MD_DIVZERO_FLAG_EN
    logic             div_zero;
`endif

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    md_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
`ifdef MD_DIVZERO_FLAG_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi,lo} straight from the arithmetic definitions
    function automatic logic [63:0] mdResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sx = $signed(x);
        longint     sy = $signed(y);
        longint     q;
        longint     r;
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        logic [63:0] p;
        case (o)
            3'd0: p = sx * sy;
            3'd1: p = ux * uy;
            3'd2: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    logic [31:0] mHi = '0, mLo = '0;
    logic [63:0] mPend = '0;
    int          mRemain = 0;
    bit          mDone = 0, mDz = 0, mPendDz = 0;

    always @(posedge clk) begin
        if (reset) begin
            mHi = '0; mLo = '0; mRemain = 0; mDone = 0; mDz = 0;
            chkEn = 1'b1;
        end else begin
            mDone = 0;
            if (mRemain > 0) begin
                mRemain--;
                if (mRemain == 0) begin
                    {mHi, mLo} = mPend;
                    mDone = 1;
                    mDz = mPendDz;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    mPend   = mdResult(op, a, b);
                    mPendDz = (op >= 3'd2) && (b == 0);
                    mRemain = WIDTH + 1;
                    mDz     = 0;
                end else if (op == 3'd4) begin
                    mHi = a; mDz = 0;
                end else if (op == 3'd5) begin
                    mLo = a; mDz = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            cmp("busy", {31'b0, busy}, {31'b0, mRemain > 0});
            cmp("done", {31'b0, done}, {31'b0, mDone});
            cmp("hi", hi, mHi);
            cmp("lo", lo, mLo);
`ifdef MD_DIVZERO_FLAG_EN
            cmp("div_zero", {31'b0, div_zero}, {31'b0, mDz});
`endif
        end
    end

    // Caller sits at posedge+1; start is sampled on the next edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string nm, output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 100 cycles", nm);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    int lat;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp("reset_hi", hi, 32'h0);
        cmp("reset_lo", lo, 32'h0);
        cmp("reset_busy", {31'b0, busy}, 32'h0);
        cmp("reset_done", {31'b0, done}, 32'h0);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        waitDone("mult", lat);
        cmp("mult_latency", lat, WIDTH + 1);
        cmp("mult_hi", hi, 32'hFFFF_FFFF);
        cmp("mult_lo", lo, 32'hFFFF_FFEB);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu", lat);
        cmp("multu_hi", hi, 32'hFFFF_FFFE);
        cmp("multu_lo", lo, 32'h0000_0001);
        issue(3'd3, 32'd100, 32'd7);
        waitDone("divu", lat);
        cmp("divu_latency", lat, WIDTH + 1);
        cmp("divu_lo", lo, 32'h0000_000E);
        cmp("divu_hi", hi, 32'h0000_0002);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_neg", lat);
        cmp("div_neg_lo", lo, 32'hFFFF_FFFD);
        cmp("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div_ovf", lat);
        cmp("div_ovf_lo", lo, 32'h8000_0000);
        cmp("div_ovf_hi", hi, 32'h0);

        issue(3'd3, 32'd5, 32'd0);
        waitDone("divz", lat);
        cmp("divz_lo", lo, 32'hFFFF_FFFF);
        cmp("divz_hi", hi, 32'd5);
`ifdef MD_DIVZERO_FLAG_EN
        cmp("divz_flag", {31'b0, div_zero}, 32'd1);
`endif

        issue(3'd4, 32'h1234_5678, 32'd0);
        cmp("mthi_hi", hi, 32'h1234_5678);
        cmp("mthi_done", {31'b0, done}, 32'd0);
`ifdef MD_DIVZERO_FLAG_EN
        cmp("divz_clear", {31'b0, div_zero}, 32'd0);
`endif

        issue(3'd0, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        #1 issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        waitDone("mtlo_busy", lat);
        cmp("mtlo_busy_lo", lo, 32'd15);
        cmp("mtlo_busy_hi", hi, 32'd0);

        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cmp("abort_busy", {31'b0, busy}, 32'd0);
        cmp("abort_hi", hi, 32'd0);
        cmp("abort_lo", lo, 32'd0);
        issue(3'd0, 32'd3, 32'd4);
        waitDone("after_abort", lat);
        cmp("after_abort_lo", lo, 32'd12);
        cmp("after_abort_hi", hi, 32'd0);

        for (int i = 0; i < 8000; i++) begin
            start = ($urandom % 3 == 0);
            op    = 3'($urandom % 8);
            a     = pick();
            b     = pick();
            reset = ($urandom % 1500 == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
